exmul_mac_acc: RTL and testbench

//  Accumulator stage directly downstream of the 64x64 Vedic multiplier (128-bit product).

---
 rtl/exmul_pkg.sv | 10 +
 rtl/exmul_acc_add.sv | 11 +
 rtl/exmul_mac_acc.sv | 115 +++++++++++
 tb/tb_exmul_mac_acc.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/exmul_pkg.sv
// Shared constants and state encoding for the multiplier accumulator stage.
package exmul_pkg;
    localparam int PROD_W = 128;
    localparam int GUARD  = 8;
    localparam int ACC_W  = PROD_W + GUARD;
    localparam int CNT_W  = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_FULL} state_t;
endpackage

// File: rtl/exmul_acc_add.sv
// Accumulator adder: acc + zero-extended product, carry-out flags ACC_W overflow.
module exmul_acc_add
    import exmul_pkg::*;
(
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);
    assign {carry, sum} = {1'b0, acc} + {{(GUARD + 1){1'b0}}, prod};
endmodule

// File: rtl/exmul_mac_acc.sv
// Dot-product accumulator behind the 64x64 multiplier; holds one completed result.
//  state  | meaning
//  S_IDLE | no partial vector, acc/cnt zero
//  S_ACC  | partial vector being accumulated
//  S_FULL | result held in out_* until taken
module exmul_mac_acc
    import exmul_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    input  logic              acc_clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);
    state_t             state, state_nxt;
    logic [ACC_W-1:0]   acc, acc_base, add_sum;
    logic [CNT_W-1:0]   cnt, cnt_base, cnt_inc;
    logic               ovf, ovf_base, ovf_inc;
    logic               add_carry, sat_hit;
    logic               rdy_en, accept, take;

    // Holds in_ready low until the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdy_en <= 1'b0;
        else     rdy_en <= 1'b1;
    end

    assign out_valid = (state == S_FULL);
    assign in_ready  = rdy_en & ((state != S_FULL) | out_ready);
    assign accept    = in_valid & in_ready;
    assign take      = out_valid & out_ready;

    // acc_clear discards the partial vector before the current beat is added.
    assign acc_base = acc_clear ? '0 : acc;
    assign cnt_base = acc_clear ? '0 : cnt;
    assign ovf_base = acc_clear ? 1'b0 : ovf;

    exmul_acc_add u_add (
        .acc   (acc_base),
        .prod  (in_prod),
        .sum   (add_sum),
        .carry (add_carry)
    );

    assign cnt_inc = (cnt_base == CNT_MAX) ? cnt_base
                                           : cnt_base + {{(CNT_W - 1){1'b0}}, 1'b1};
    assign sat_hit = (cnt_inc == CNT_MAX);
    assign ovf_inc = ovf_base | add_carry | sat_hit;

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (accept) state_nxt = in_last ? S_FULL : S_ACC;
            end
            S_ACC: begin
                if (accept && in_last) state_nxt = S_FULL;
                else if (!accept && acc_clear) state_nxt = S_IDLE;
            end
            S_FULL: begin
                if (take) begin
                    if (accept) state_nxt = in_last ? S_FULL : S_ACC;
                    else        state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (accept) begin
            if (in_last) begin
                acc <= '0;
                cnt <= '0;
                ovf <= 1'b0;
            end else begin
                acc <= add_sum;
                cnt <= cnt_inc;
                ovf <= ovf_inc;
            end
        end else if (acc_clear) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else if (accept && in_last) begin
            out_sum   <= add_sum;
            out_count <= cnt_inc;
            out_ovf   <= ovf_inc;
        end
    end
endmodule

// File: tb/tb_exmul_mac_acc.sv
// Directed bench for exmul_mac_acc: vector table plus hold, saturation and reset sequences.
module tb_exmul_mac_acc;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_prod = '0;
    logic         in_last = 1'b0;
    logic         acc_clear = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [135:0] out_sum;
    logic [7:0]   out_count;
    logic         out_ovf;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic         vld;
        logic [127:0] prod;
        logic         last;
        logic         clr;
        logic         exp_v;
        logic [135:0] exp_sum;
        logic [7:0]   exp_cnt;
        logic         exp_ovf;
    } vec_t;

    vec_t tbl[$];

    exmul_mac_acc dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .acc_clear (acc_clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [127:0] p, input logic l,
                         input logic c, input logic r);
        in_valid  = v;
        in_prod   = p;
        in_last   = l;
        acc_clear = c;
        out_ready = r;
    endtask

    function automatic vec_t mk(input logic v, input logic [127:0] p, input logic l,
                                input logic c, input logic ev, input logic [135:0] es,
                                input logic [7:0] ec, input logic eo);
        vec_t t;
        t.vld = v; t.prod = p; t.last = l; t.clr = c;
        t.exp_v = ev; t.exp_sum = es; t.exp_cnt = ec; t.exp_ovf = eo;
        return t;
    endfunction

    logic [127:0] pmax;
    logic [135:0] two_max, sat_sum;

    initial begin
        pmax    = '1;
        two_max = (136'd1 << 129) - 136'd2;
        sat_sum = (136'd1 << 136) - 136'd256;

        // test 1: 3,5,7
        tbl.push_back(mk(1, 3,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 5,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 7,  1, 0, 1, 15, 3, 0));
        tbl.push_back(mk(0, 0,  0, 0, 0, 0, 0, 0));
        // test 4: 10,20 then clear with 4 (last)
        tbl.push_back(mk(1, 10, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 20, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4,  1, 1, 1, 4, 1, 0));
        tbl.push_back(mk(0, 0,  0, 0, 0, 0, 0, 0));
        // clear with no beat mid-vector, then a 1-term vector
        tbl.push_back(mk(1, 5,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0,  0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 6,  1, 0, 1, 6, 1, 0));
        // in_last without in_valid ignored
        tbl.push_back(mk(0, 0,  1, 0, 0, 0, 0, 0));
        // test 6: back-to-back 1-beat vectors
        tbl.push_back(mk(1, 1,  1, 0, 1, 1, 1, 0));
        tbl.push_back(mk(1, 2,  1, 0, 1, 2, 1, 0));
        tbl.push_back(mk(1, 3,  1, 0, 1, 3, 1, 0));
        tbl.push_back(mk(0, 0,  0, 0, 0, 0, 0, 0));
        // test 2a: two max products
        tbl.push_back(mk(1, pmax, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, pmax, 1, 0, 1, two_max, 2, 0));
        tbl.push_back(mk(0, 0,  0, 0, 0, 0, 0, 0));

        // reset state
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_count", out_count, 0);
        check("rst_out_ovf", out_ovf, 0);
        #11;
        rst = 1'b0;
        #1;
        check("rel_in_ready_before_edge", in_ready, 0);
        cyc();
        check("rel_in_ready_after_edge", in_ready, 1);

        foreach (tbl[i]) begin
            drive(tbl[i].vld, tbl[i].prod, tbl[i].last, tbl[i].clr, 1'b1);
            cyc();
            check($sformatf("tbl%0d_valid", i), out_valid, tbl[i].exp_v);
            if (tbl[i].exp_v) begin
                check($sformatf("tbl%0d_sum", i), out_sum, tbl[i].exp_sum);
                check($sformatf("tbl%0d_count", i), out_count, tbl[i].exp_cnt);
                check($sformatf("tbl%0d_ovf", i), out_ovf, tbl[i].exp_ovf);
            end
        end

        // test 3: hold with out_ready low
        drive(1, 3, 1, 0, 0);
        cyc();
        check("hold_valid", out_valid, 1);
        drive(1, 99, 1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            #3;
            check($sformatf("hold%0d_in_ready", k), in_ready, 0);
            cyc();
            check($sformatf("hold%0d_valid", k), out_valid, 1);
            check($sformatf("hold%0d_sum", k), out_sum, 3);
            check($sformatf("hold%0d_count", k), out_count, 1);
            check($sformatf("hold%0d_ovf", k), out_ovf, 0);
        end
        drive(1, 8, 0, 0, 1);
        #3;
        check("drain_in_ready", in_ready, 1);
        cyc();
        check("drain_valid", out_valid, 0);
        drive(1, 1, 1, 0, 1);
        cyc();
        check("drain_next_sum", out_sum, 9);
        check("drain_next_count", out_count, 2);
        drive(0, 0, 0, 0, 1);
        cyc();

        // test 2b: 256 max beats saturate count
        for (int k = 0; k < 256; k++) begin
            drive(1, pmax, (k == 255), 0, 1);
            cyc();
        end
        check("sat_valid", out_valid, 1);
        check("sat_sum", out_sum, sat_sum);
        check("sat_count", out_count, 255);
        check("sat_ovf", out_ovf, 1);
        drive(1, 5, 1, 0, 1);
        cyc();
        check("post_sat_sum", out_sum, 5);
        check("post_sat_count", out_count, 1);
        check("post_sat_ovf", out_ovf, 0);
        drive(0, 0, 0, 0, 1);
        cyc();

        // test 5: reset mid-vector
        drive(1, 20, 0, 0, 1);
        cyc();
        drive(1, 30, 0, 0, 1);
        cyc();
        drive(0, 0, 0, 0, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_valid", out_valid, 0);
        check("rstmid_in_ready", in_ready, 0);
        check("rstmid_sum", out_sum, 0);
        check("rstmid_count", out_count, 0);
        check("rstmid_ovf", out_ovf, 0);
        cyc();
        #2;
        rst = 1'b0;
        cyc();
        drive(1, 9, 1, 0, 1);
        cyc();
        check("rstmid_next_sum", out_sum, 9);
        check("rstmid_next_count", out_count, 1);

        // reset while holding a result
        drive(1, 7, 1, 0, 0);
        cyc();
        check("rstfull_pre_valid", out_valid, 1);
        drive(0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check("rstfull_valid", out_valid, 0);
        check("rstfull_sum", out_sum, 0);
        check("rstfull_count", out_count, 0);
        cyc();
        #2;
        rst = 1'b0;
        cyc();
        drive(1, 9, 1, 0, 1);
        cyc();
        check("rstfull_next_valid", out_valid, 1);
        check("rstfull_next_sum", out_sum, 9);
        drive(0, 0, 0, 0, 1);
        cyc();
        check("final_idle_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
